// File: rtl/edge_rate_meter.sv
// edge_rate_meter: counts rising edges of an asynchronous signal over a
// fixed gate window of GATE_CYCLES clk cycles, one-shot or continuous.
module edge_rate_meter #(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             overflow
);

  localparam int unsigned      GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              win_ovf_q, win_ovf_d;
  logic [CNT_W-1:0]  result_q, result_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              s1_q, s2_q, s3_q;
  logic              rise_c;

  // Synchronizer plus delay flop; runs in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_c = s2_q & ~s3_q;

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gate_q     <= '0;
      cnt_q      <= '0;
      win_ovf_q  <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      cnt_q      <= cnt_d;
      win_ovf_q  <= win_ovf_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic; the final MEASURE cycle's edge is folded into the result.
  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    cnt_d      = cnt_q;
    win_ovf_d  = win_ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = MEASURE;
          gate_d    = '0;
          cnt_d     = '0;
          win_ovf_d = 1'b0;
        end
      end
      MEASURE: begin
        gate_d = gate_q + GATE_W'(1);
        if (rise_c) begin
          if (cnt_q == CNT_MAX) begin
            win_ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (gate_q == GATE_LAST) begin
          state_d    = DONE;
          result_d   = cnt_d;
          overflow_d = win_ovf_d;
        end
      end
      DONE: begin
        if (continuous) begin
          state_d   = MEASURE;
          gate_d    = '0;
          cnt_d     = '0;
          win_ovf_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_edge_rate_meter.sv
// Testbench for edge_rate_meter: three instances with different windows,
// checked against an edge-counting model over the recorded input history.
module tb_edge_rate_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sig_in = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic        cont_a = 1'b0, cont_b = 1'b0, cont_c = 1'b0;
  logic        busy_a, busy_b, busy_c;
  logic        val_a, val_b, val_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [15:0] res_a, res_c;
  logic [3:0]  res_b;

  edge_rate_meter #(.GATE_CYCLES(1000), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start_a), .continuous(cont_a),
    .busy(busy_a), .result(res_a), .result_valid(val_a), .overflow(ovf_a));

  edge_rate_meter #(.GATE_CYCLES(100), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start_b), .continuous(cont_b),
    .busy(busy_b), .result(res_b), .result_valid(val_b), .overflow(ovf_b));

  edge_rate_meter #(.GATE_CYCLES(20), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start_c), .continuous(cont_c),
    .busy(busy_c), .result(res_c), .result_valid(val_c), .overflow(ovf_c));

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic        hist[$];
  int          cyc = 0;
  int          mode = 0;
  logic        rnd_val = 1'b0;
  int          rnd_left = 0;
  int          sel = 0;
  logic        o_busy, o_val, o_ovf;
  logic [15:0] o_res;

  // Observe the instance under test.
  always_comb begin
    case (sel)
      0:       begin o_busy = busy_a; o_val = val_a; o_ovf = ovf_a; o_res = res_a; end
      1:       begin o_busy = busy_b; o_val = val_b; o_ovf = ovf_b; o_res = 16'(res_b); end
      default: begin o_busy = busy_c; o_val = val_c; o_ovf = ovf_c; o_res = res_c; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; cycle index cyc spans posedge cyc .. posedge cyc+1.
  task automatic step();
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    cyc = hist.size();
    case (mode)
      0: sig_in = 1'b0;
      1: sig_in = 1'b1;
      2: sig_in = cyc[1];
      3: sig_in = cyc[0];
      default: begin
        if (rnd_left == 0) begin
          rnd_val  = ~rnd_val;
          rnd_left = int'($urandom_range(2, 6));
        end
        rnd_left--;
        sig_in = rnd_val;
      end
    endcase
    hist.push_back(sig_in);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_start(input int s);
    case (s)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
  endtask

  // Rising edges as seen after two sync stages, during the g cycles after start cycle t0.
  function automatic int exp_raw(input int t0, input int g);
    int c = 0;
    for (int m = t0 + 1; m <= t0 + g; m++)
      if (hist[m-2] && !hist[m-3]) c++;
    return c;
  endfunction

  // Run one window started in cycle t0 and check the DONE cycle against the model.
  task automatic run_window(input int t0, input int g, input int w, input int drop_at,
                            input int sw_at, input string tag);
    int vcount = 0;
    int vcyc = -1;
    int raw, maxv;
    for (int k = 1; k <= g + 1; k++) begin
      step();
      if (o_val === 1'b1) begin
        vcount++;
        vcyc = cyc;
      end
      if (k == 1) chk({tag, "_busy_first"}, 32'(o_busy), 1);
      if (k == drop_at) cont_c = 1'b0;
      if (k == sw_at) mode = 1;
    end
    raw  = exp_raw(t0, g);
    maxv = (1 << w) - 1;
    chk({tag, "_vcyc"}, vcyc, t0 + g + 1);
    chk({tag, "_vcount"}, vcount, 1);
    chk({tag, "_busy_done"}, 32'(o_busy), 1);
    chk({tag, "_result"}, 32'(o_res), (raw > maxv) ? maxv : raw);
    chk({tag, "_ovf"}, 32'(o_ovf), (raw > maxv) ? 1 : 0);
  endtask

  initial begin
    int t0;
    int vc;

    // Reset state on all instances
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_valid", 32'(o_val), 0);
      chk("rst_result", 32'(o_res), 0);
      chk("rst_ovf", 32'(o_ovf), 0);
    end
    steps(3);
    rst = 1'b0;
    steps(5);

    // Divide-by-4 input, one-shot, 1000-cycle window
    sel = 0; mode = 2;
    steps(4);
    do_start(0); t0 = cyc;
    run_window(t0, 1000, 16, -1, -1, "div4");
    chk("div4_250", 32'(o_res), 250);
    step();
    chk("div4_busy_after", 32'(o_busy), 0);
    chk("div4_valid_after", 32'(o_val), 0);

    // Static low, single transition, static high on the 20-cycle instance
    sel = 2; mode = 0;
    steps(5);
    do_start(2); t0 = cyc;
    run_window(t0, 20, 16, -1, -1, "low");
    chk("low_zero", 32'(o_res), 0);
    steps(2);
    do_start(2); t0 = cyc;
    run_window(t0, 20, 16, -1, 8, "single");
    chk("single_one", 32'(o_res), 1);
    steps(5);
    do_start(2); t0 = cyc;
    run_window(t0, 20, 16, -1, -1, "high");
    chk("high_zero", 32'(o_res), 0);

    // Saturation on the 4-bit instance, then a quiet window clears it
    sel = 1; mode = 3;
    steps(5);
    do_start(1); t0 = cyc;
    run_window(t0, 100, 4, -1, -1, "sat");
    chk("sat_15", 32'(o_res), 15);
    chk("sat_ovf1", 32'(o_ovf), 1);
    mode = 0;
    steps(5);
    do_start(1); t0 = cyc;
    run_window(t0, 100, 4, -1, -1, "unsat");
    chk("unsat_ovf0", 32'(o_ovf), 0);

    // Continuous mode, then drop continuous mid-window
    sel = 2; mode = 2;
    steps(4);
    cont_c = 1'b1;
    do_start(2); t0 = cyc;
    for (int w = 0; w < 3; w++) begin
      run_window(t0, 20, 16, -1, -1, "cont");
      chk("cont_5", 32'(o_res), 5);
      t0 = cyc;
    end
    run_window(t0, 20, 16, 8, -1, "cont_last");
    vc = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (o_val === 1'b1) vc++;
    end
    chk("cont_no_more_strobes", vc, 0);
    chk("cont_idle", 32'(o_busy), 0);

    // start ignored while busy, including in the DONE cycle
    mode = 0;
    steps(5);
    do_start(2); t0 = cyc;
    vc = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (o_val === 1'b1) vc++;
      if (cyc == t0 + 5 || cyc == t0 + 21) do_start(2);
    end
    chk("ignore_strobes", vc, 1);
    chk("ignore_idle", 32'(o_busy), 0);

    // Randomized windows on the 20-cycle and saturating instances
    mode = 4;
    sel = 2;
    for (int r = 0; r < 6; r++) begin
      steps(int'($urandom_range(1, 7)));
      do_start(2); t0 = cyc;
      run_window(t0, 20, 16, -1, -1, "rand_c");
    end
    sel = 1;
    for (int r = 0; r < 3; r++) begin
      steps(int'($urandom_range(1, 7)));
      do_start(1); t0 = cyc;
      run_window(t0, 100, 4, -1, -1, "rand_b");
    end

    // Reset mid-window on the 1000-cycle instance, then a fresh window
    sel = 0;
    steps(3);
    do_start(0);
    steps(11);
    chk("mid_busy", 32'(o_busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(o_busy), 0);
    chk("mid_rst_valid", 32'(o_val), 0);
    chk("mid_rst_result", 32'(o_res), 0);
    chk("mid_rst_ovf", 32'(o_ovf), 0);
    vc = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_val === 1'b1) vc++;
    end
    chk("mid_rst_no_strobe", vc, 0);
    rst = 1'b0;
    steps(5);
    do_start(0); t0 = cyc;
    run_window(t0, 1000, 16, -1, -1, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_rate_meter.md
# edge_rate_meter

Measures the rate of a slow, asynchronous signal by counting its rising edges over a fixed gate window of GATE_CYCLES `clk` cycles. It sits directly downstream of the clock divider: its `sig_in` consumes the divided clock, such as the divide-by-4 output. It reports one edge count per window with a single-cycle valid strobe, in one-shot or continuous mode.

## Interface
- GATE_CYCLES, 1000, gate window length in `clk` cycles; must be ≥ 2.
- CNT_W, 16, width of edge counter and result.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sig_in  in  1  measured signal, asynchronous to `clk`.
- start  in  1  single-cycle request to begin a window; ignored while `busy`=1.
- continuous  in  1  1 = re-arm automatically after each window; sampled in DONE.
- busy  out  1  1 in MEASURE and DONE.
- result  out  CNT_W  edge count of last completed window; holds until next DONE.
- result_valid  out  1  one-cycle strobe, high in DONE.
- overflow  out  1  1 if the last completed window saturated; updated with `result`.

## Operation
- Input path:
  - `sig_in` passes through a 2-flop synchronizer (s1, s2), then a delay flop s3.
  - Internal `edge` = s2 & ~s3.
  - Synchronizer and edge flops run in every state.
- Gate counter width is clog2(GATE_CYCLES). Edge counter is CNT_W bits and saturates at 2^CNT_W−1.
- FSM states: IDLE, MEASURE, DONE.
- IDLE:
  - `start`=1 → MEASURE.
  - On that transition, gate counter and edge counter clear to 0 and the window overflow flag clears.
- MEASURE:
  - Each cycle, gate counter +1.
  - If `edge`=1: edge counter +1; if already at max, it holds and the window overflow flag sets.
  - When gate counter = GATE_CYCLES−1, that cycle's edge still counts, then → DONE.
  - The window is therefore exactly GATE_CYCLES cycles.
- DONE (exactly one cycle):
  - `result` = final edge count, `overflow` = window overflow flag (both registered on the MEASURE→DONE edge).
  - `result_valid`=1.
  - Edges in the DONE cycle are not counted.
  - If `continuous`=1 → MEASURE, with counters cleared as for a start. Otherwise → IDLE.
- `start` in MEASURE or DONE is ignored, not queued.
- Dropping `continuous` mid-window lets the current window finish normally; then → IDLE.
- Reset, async at any time including mid-window:
  - state = IDLE; all counters and synchronizer flops = 0.
  - `result`=0, `result_valid`=0, `overflow`=0, `busy`=0.
  - No partial result is reported.

## Timing
- Edge latency: a rising `sig_in` is counted 2–3 `clk` cycles later (synchronizer plus edge flop). The window is defined on the synchronized signal.
- `start` at cycle T:
  - MEASURE covers T+1 … T+GATE_CYCLES.
  - DONE at T+GATE_CYCLES+1, with `result_valid` and new `result`/`overflow` visible in that cycle.
- In continuous mode, windows repeat every GATE_CYCLES+1 cycles, with a one-cycle DONE gap between them.
- `busy` rises the cycle after `start` and falls the cycle after DONE in one-shot mode.
- Minimum resolvable `sig_in` high/low time: ≥ 2 `clk` cycles. Shorter pulses may be lost; this is not detected.
- Maximum countable rate: one edge every 2 cycles, i.e. GATE_CYCLES/2 edges per window.

## Test plan
- Divide-by-4 input: GATE_CYCLES=1000, CNT_W=16, `sig_in` = clk/4 from the divider, one-shot `start` → one `result_valid` pulse 1001 cycles after `start`; `result`=250, `overflow`=0; `busy` then 0.
- Static input: `sig_in` held 0, then held 1 → `result`=0 both windows. A single 0→1 transition mid-window → `result`=1.
- Saturation: CNT_W=4, GATE_CYCLES=100, `sig_in` toggling every cycle (50 edges) → `result`=15, `overflow`=1. The next window with `sig_in`=0 → `result`=0, `overflow`=0.
- Continuous mode: GATE_CYCLES=20, `sig_in` = clk/4, `continuous`=1 → `result_valid` every 21 cycles, `result`=5 each window. Drop `continuous` mid-window → exactly one more strobe, then IDLE.
- `start` ignored while busy: pulse `start` at cycles T, T+5, T+GATE_CYCLES+1 (the DONE cycle) → only one window, one strobe.
- Reset mid-window: assert `rst` 10 cycles into MEASURE → all outputs 0 immediately, no `result_valid`. A fresh `start` after release gives the correct count.
